// File: rtl/data_compare_serial.sv
// Serial multi-nibble magnitude comparator: walks two operands LSB nibble first
// through a 4-bit cascade compare, one nibble per clock, producing a one-hot result.
module data_compare_serial #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iStart,
   input  logic [4*NIBBLES-1:0]   iData_a,
   input  logic [4*NIBBLES-1:0]   iData_b,
   input  logic [2:0]             iData,
   output logic [2:0]             oData,
   output logic                   oBusy,
   output logic                   oDone
);

   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST_K = CW'(NIBBLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   state_t                 stateNext;
   logic [4*NIBBLES-1:0]   regA;
   logic [4*NIBBLES-1:0]   regB;
   logic [2:0]             cascade;
   logic [2:0]             cascadeIn;
   logic [2:0]             cmpRes;
   logic [CW-1:0]          k;
   logic [3:0]             aNib;
   logic [3:0]             bNib;
   logic                   lastNib;

   assign aNib    = regA[{k, 2'b00} +: 4];
   assign bNib    = regB[{k, 2'b00} +: 4];
   assign lastNib = (k == LAST_K);

   // Anything other than a single hot bit is treated as "equal so far".
   always_comb begin
      case (iData)
         3'b100, 3'b010, 3'b001: cascadeIn = iData;
         default:                cascadeIn = 3'b001;
      endcase
   end

   always_comb begin
      cmpRes = cascade;
      if (aNib > bNib)      cmpRes = 3'b100;
      else if (aNib < bNib) cmpRes = 3'b010;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) state <= IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (iStart) stateNext = RUN;
         RUN:     if (lastNib) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      oBusy = (state == RUN);
   end

   // Counter parks at the last nibble instead of wrapping; the next start clears it.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         regA    <= '0;
         regB    <= '0;
         cascade <= 3'b001;
         k       <= '0;
         oData   <= '0;
         oDone   <= 1'b0;
      end else begin
         oDone <= 1'b0;
         case (state)
            IDLE: begin
               if (iStart) begin
                  regA    <= iData_a;
                  regB    <= iData_b;
                  cascade <= cascadeIn;
                  k       <= '0;
               end
            end
            RUN: begin
               cascade <= cmpRes;
               if (lastNib) begin
                  oData <= cmpRes;
                  oDone <= 1'b1;
               end else begin
                  k <= k + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_compare_serial.sv
// Self-checking bench for data_compare_serial: directed cases plus randomized
// operands checked against a whole-word magnitude reference model.
module tb_data_compare_serial;

   localparam int unsigned NIB = 4;

   logic          iClk = 1'b0;
   logic          iRst = 1'b1;
   logic          iStart = 1'b0;
   logic [15:0]   iData_a = '0;
   logic [15:0]   iData_b = '0;
   logic [2:0]    iData = 3'b001;
   logic [2:0]    oData;
   logic          oBusy;
   logic          oDone;

   int nChecks = 0;
   int nFails  = 0;
   logic [2:0] lastData = 3'b000;

   data_compare_serial #(.NIBBLES(NIB)) dut (
      .iClk    (iClk),
      .iRst    (iRst),
      .iStart  (iStart),
      .iData_a (iData_a),
      .iData_b (iData_b),
      .iData   (iData),
      .oData   (oData),
      .oBusy   (oBusy),
      .oDone   (oDone)
   );

   always #5 iClk = ~iClk;

   task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Whole-operand magnitude compare; cascade-in only matters when A == B.
   function automatic logic [2:0] refCompare(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] c);
      if (a > b) return 3'b100;
      if (a < b) return 3'b010;
      if (c == 3'b100 || c == 3'b010 || c == 3'b001) return c;
      return 3'b001;
   endfunction

   task automatic runOne(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                         input string tag);
      logic [2:0] exp;
      exp = refCompare(a, b, c);
      @(negedge iClk);
      iData_a = a; iData_b = b; iData = c; iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      checkVal({tag, "_busyE0"}, oBusy, 1);
      checkVal({tag, "_doneE0"}, oDone, 0);
      for (int i = 1; i <= NIB; i++) begin
         // Inputs wander during RUN; the latched operands must not follow.
         iData_a = 16'($urandom); iData_b = 16'($urandom); iData = 3'($urandom);
         @(posedge iClk); #1;
         if (i < NIB) begin
            checkVal({tag, "_busy"}, oBusy, 1);
            checkVal({tag, "_doneEarly"}, oDone, 0);
            checkVal({tag, "_hold"}, oData, lastData);
         end else begin
            checkVal({tag, "_done"}, oDone, 1);
            checkVal({tag, "_busyEnd"}, oBusy, 0);
            checkVal({tag, "_result"}, oData, exp);
         end
      end
      @(posedge iClk); #1;
      checkVal({tag, "_donePulse"}, oDone, 0);
      checkVal({tag, "_resultHold"}, oData, exp);
      lastData = exp;
   endtask

   initial begin
      int doneCnt;
      logic [15:0] ra, rb;
      #1;
      checkVal("rst_data", oData, 0);
      checkVal("rst_busy", oBusy, 0);
      checkVal("rst_done", oDone, 0);
      @(negedge iClk);
      iRst = 1'b0;

      runOne(16'h1234, 16'h1235, 3'b001, "lsbLess");
      runOne(16'hABCD, 16'hABCD, 3'b100, "eqGt");
      runOne(16'hABCD, 16'hABCD, 3'b010, "eqLt");
      runOne(16'hABCD, 16'hABCD, 3'b001, "eqEq");
      runOne(16'h8000, 16'h7FFF, 3'b010, "msbWins");
      runOne(16'h5555, 16'h5555, 3'b011, "bad011");
      runOne(16'h5555, 16'h5555, 3'b111, "bad111");
      runOne(16'h5555, 16'h5555, 3'b000, "bad000");

      // Start held through RUN: ignored there, then sampled one edge after completion.
      @(negedge iClk);
      iData_a = 16'h0001; iData_b = 16'h0002; iData = 3'b001; iStart = 1'b1;
      @(posedge iClk); #1;
      iData_a = 16'hFFFF; iData_b = 16'h0000;
      checkVal("b2b_busyE0", oBusy, 1);
      doneCnt = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge iClk); #1;
         if (oDone) doneCnt++;
         if (i == 4) begin
            checkVal("b2b_done1", oDone, 1);
            checkVal("b2b_res1", oData, 3'b010);
         end
         if (i == 5) begin
            checkVal("b2b_busyE5", oBusy, 1);
            checkVal("b2b_doneE5", oDone, 0);
            iStart = 1'b0;
         end
         if (i == 9) begin
            checkVal("b2b_done2", oDone, 1);
            checkVal("b2b_res2", oData, 3'b100);
         end
      end
      checkVal("b2b_doneCount", doneCnt, 2);
      lastData = 3'b100;

      // Asynchronous reset in the middle of a run.
      @(negedge iClk);
      iData_a = 16'h00F0; iData_b = 16'h000F; iData = 3'b001; iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      @(posedge iClk); @(posedge iClk); #2;
      iRst = 1'b1;
      #1;
      checkVal("midRst_busy", oBusy, 0);
      checkVal("midRst_done", oDone, 0);
      checkVal("midRst_data", oData, 0);
      @(negedge iClk);
      iRst = 1'b0;
      lastData = 3'b000;
      doneCnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge iClk); #1;
         if (oDone) doneCnt++;
      end
      checkVal("midRst_noDone", doneCnt, 0);
      checkVal("midRst_busyIdle", oBusy, 0);
      runOne(16'h00F0, 16'h000F, 3'b001, "postRst");

      for (int n = 0; n < 40; n++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       rb = 16'($urandom);
            1:       rb = ra;
            default: rb = ra ^ (16'h000F << (4 * $urandom_range(0, 3)));
         endcase
         runOne(ra, rb, 3'($urandom_range(0, 7)), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/data_compare_serial.md
# data_compare_serial

Sequential multi-nibble magnitude comparator that walks two wide operands through a 4-bit cascade compare, one nibble per clock, LSB nibble first. The result of each nibble feeds the cascade input of the next more significant nibble. It sits upstream and downstream of the 4-bit comparator slice: it generates the slice's cascade input and consumes its 3-bit result. The final result uses the same 3-bit one-hot encoding, so another comparator stage can consume it directly.

## Interface
- NIBBLES, 4, operand width in nibbles (>= 1); operand width W = 4*NIBBLES.
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  reset, asynchronous, active-high.
- iStart  input  1  start request, sampled only in IDLE.
- iData_a  input  W  operand A, latched on start.
- iData_b  input  W  operand B, latched on start.
- iData  input  3  cascade-in from a less significant stage, latched on start. Encoding: 100 = A>B, 010 = A<B, 001 = A=B.
- oData  output  3  final compare result, same encoding; holds until the next completion.
- oBusy  output  1  high while in RUN.
- oDone  output  1  one-cycle pulse when oData is updated.

## Operation
- Cascade rule per nibble k, with a_k = A[4k+3:4k], b_k = B[4k+3:4k] and c = cascade register:
  - a_k > b_k gives 100.
  - a_k < b_k gives 010.
  - a_k == b_k gives c.
- Non-one-hot iData (000, 011, 101, 110, 111) is latched as 001.
- State IDLE:
  - iStart = 1 latches iData_a, iData_b and the sanitised iData into the cascade register.
  - Clears the nibble counter k to 0.
  - Goes to RUN and sets oBusy = 1.
  - iStart = 0 leaves the state in IDLE.
- State RUN, every edge:
  - Compares nibble k, writes the result to the cascade register and increments k.
  - When k = NIBBLES-1, also loads oData with the result, pulses oDone, clears oBusy and goes to IDLE.
- iStart is ignored while in RUN. The latched operands are frozen; changes on iData_a, iData_b or iData during RUN have no effect.
- Counter width is clog2(NIBBLES), minimum 1 bit. The counter never exceeds NIBBLES-1 and does not wrap within a run.
- Reset values (asynchronous, effective immediately):
  - State = IDLE, oBusy = 0, oDone = 0, oData = 000.
  - Cascade register = 001, k = 0.
- Reset mid-RUN aborts the run: no oDone, oData = 000.

## Timing
- Start sampled at edge E0, which enters RUN. Edges E1..EN process nibbles 0..NIBBLES-1.
- At edge EN: oData updated, oDone = 1 for exactly one cycle (EN to EN+1), oBusy = 0, state = IDLE.
- Latency from the start-sampling edge to oDone is NIBBLES cycles. oBusy is high for exactly NIBBLES cycles.
- Back-to-back: iStart high in the cycle after EN is sampled at EN+1. The maximum rate is one compare per NIBBLES+1 cycles.
- NIBBLES = 1: oDone at E1.
- oData changes only at a completion edge or on reset. Between completions it holds its value.
- oDone is never asserted in the same cycle as oBusy.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- NIBBLES=4, A=16'h1234, B=16'h1235, iData=001, start at E0:
  - oBusy = 1 at E0..E3.
  - oData = 010 and oDone = 1 at E4; oData holds 010 afterwards.
- A=B=16'hABCD: with iData=100 the result is oData = 100; with iData=010 it is 010; with iData=001 it is 001.
- A=16'h8000, B=16'h7FFF, iData=010: oData = 100. The MSB nibble overrides the lower nibbles, where A < B.
- Ignored start and back-to-back:
  - Start A=16'h0001, B=16'h0002. Hold iStart = 1 with A=16'hFFFF, B=16'h0000 through RUN.
  - Result at E4 is 010.
  - The second start is sampled at E5 and gives 100 at E9, with exactly one oDone per run.
- Reset mid-run: start A=16'h00F0, B=16'h000F, assert iRst between E2 and E3.
  - oBusy, oDone and oData = 000 go low immediately, and no oDone follows.
  - After release, a new start completes normally: A=16'h00F0 vs B=16'h000F gives 100.
- Invalid cascade: A=B=16'h5555, iData=011: oData = 001. Same operands with iData=111 also give 001.
